// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// utils_pkg   : shared helpers (binary-to-Gray conversion).
// fifo_ptr_ctrl : pointer/flag controller for a FIFO built around an external
//                 RAM with 1-cycle registered read data.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   flush                synchronous clear of pointers and the output stage
//   wr_valid / wr_ready  producer handshake
//   rd_valid / rd_ready  consumer handshake (head word is on the RAM read data)
//   ram_we, ram_waddr    RAM write strobe / address
//   ram_re, ram_raddr    RAM read strobe / address
//   level                words accepted and not yet consumed
//   full, empty, almost_full   status flags
//   wr_ptr_gray, rd_ptr_gray   registered Gray-coded pointers
// -----------------------------------------------------------------------------

package utils_pkg;

    function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

module fifo_ptr_ctrl #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ALMOST_FULL = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_waddr,
    output logic                  ram_re,
    output logic [DEPTH_LOG2-1:0] ram_raddr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   wr_ptr_gray,
    output logic [DEPTH_LOG2:0]   rd_ptr_gray
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL);

    logic [PW-1:0] wptr, rptr;
    logic [PW-1:0] wptr_nxt, rptr_nxt;
    logic [PW-1:0] ram_cnt;
    logic          rd_valid_nxt;

    // Flags, strobes and addresses
    always_comb begin
        ram_cnt     = wptr - rptr;
        full        = (ram_cnt == FULL_CNT);
        wr_ready    = !full && !flush;
        // rst_n gate keeps the write strobe quiet while reset is held,
        // even though wr_ready reads 1 during reset
        ram_we      = wr_valid && wr_ready && rst_n;
        ram_waddr   = wptr[DEPTH_LOG2-1:0];
        // prefetch into the output stage whenever it is empty or being drained
        ram_re      = (ram_cnt != '0) && (!rd_valid || rd_ready) && !flush;
        ram_raddr   = rptr[DEPTH_LOG2-1:0];
        level       = ram_cnt + PW'(rd_valid);
        empty       = (level == '0);
        almost_full = (level >= AF_LEVEL);
    end

    // Next-state values; flush overrides any transfer in the same cycle
    always_comb begin
        wptr_nxt     = wptr + PW'(ram_we);
        rptr_nxt     = rptr + PW'(ram_re);
        rd_valid_nxt = rd_valid;
        if (ram_re) begin
            rd_valid_nxt = 1'b1;
        end else if (rd_ready) begin
            rd_valid_nxt = 1'b0;
        end
        if (flush) begin
            wptr_nxt     = '0;
            rptr_nxt     = '0;
            rd_valid_nxt = 1'b0;
        end
    end

    // Gray outputs track the post-edge pointer values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            rd_valid    <= 1'b0;
            wr_ptr_gray <= '0;
            rd_ptr_gray <= '0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            rd_valid    <= rd_valid_nxt;
            wr_ptr_gray <= PW'(utils_pkg::bin_to_gray(32'(wptr_nxt)));
            rd_ptr_gray <= PW'(utils_pkg::bin_to_gray(32'(rptr_nxt)));
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_ptr_ctrl with DEPTH_LOG2=2, ALMOST_FULL=3.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------

module tb_fifo_ptr_ctrl;

    localparam int DL2 = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           wr_valid;
    logic           wr_ready;
    logic           rd_valid;
    logic           rd_ready;
    logic           ram_we;
    logic [DL2-1:0] ram_waddr;
    logic           ram_re;
    logic [DL2-1:0] ram_raddr;
    logic [DL2:0]   level;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic [DL2:0]   wr_ptr_gray;
    logic [DL2:0]   rd_ptr_gray;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(
        .DEPTH_LOG2  (DL2),
        .ALMOST_FULL (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .ram_we      (ram_we),
        .ram_waddr   (ram_waddr),
        .ram_re      (ram_re),
        .ram_raddr   (ram_raddr),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray)
    );

    typedef struct {
        logic       flush;
        logic       wv;
        logic       rr;
        logic       wrdy;
        logic       we;
        logic [1:0] wa;
        logic       re;
        logic [1:0] ra;
        logic       rdv;
        logic [2:0] lvl;
        logic       full;
        logic       emp;
        logic       af;
        logic [2:0] wg;
        logic [2:0] rg;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(
        input logic f, input logic wv, input logic rr,
        input logic wrdy, input logic we, input logic [1:0] wa,
        input logic re, input logic [1:0] ra, input logic rdv,
        input logic [2:0] lvl, input logic fl, input logic emp,
        input logic af, input logic [2:0] wg, input logic [2:0] rg);
        vec_t v;
        v.flush = f;  v.wv = wv;  v.rr = rr;
        v.wrdy = wrdy; v.we = we; v.wa = wa;
        v.re = re;    v.ra = ra;  v.rdv = rdv;
        v.lvl = lvl;  v.full = fl; v.emp = emp;
        v.af = af;    v.wg = wg;  v.rg = rg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " level"},       32'(level), 0);
        chk({tag, " empty"},       32'(empty), 1);
        chk({tag, " full"},        32'(full), 0);
        chk({tag, " almost_full"}, 32'(almost_full), 0);
        chk({tag, " wr_ready"},    32'(wr_ready), 1);
        chk({tag, " rd_valid"},    32'(rd_valid), 0);
        chk({tag, " ram_we"},      32'(ram_we), 0);
        chk({tag, " ram_re"},      32'(ram_re), 0);
        chk({tag, " wr_gray"},     32'(wr_ptr_gray), 0);
        chk({tag, " rd_gray"},     32'(rd_ptr_gray), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          f wv rr  wrdy we wa re ra rdv lvl full emp af wg rg
        // single write, 1-cycle prefetch, rd_valid two cycles after accept
        vq.push_back(mkv(0,0,0, 1,0,0,0,0,0,0,0,1,0,0,0));
        vq.push_back(mkv(0,1,0, 1,1,0,0,0,0,0,0,1,0,0,0));
        vq.push_back(mkv(0,0,0, 1,0,1,1,0,0,1,0,0,0,1,0));
        vq.push_back(mkv(0,0,0, 1,0,1,0,1,1,1,0,0,0,1,1));
        // fill: almost_full at 3, full when RAM holds 4 (level 5)
        vq.push_back(mkv(0,1,0, 1,1,1,0,1,1,1,0,0,0,1,1));
        vq.push_back(mkv(0,1,0, 1,1,2,0,1,1,2,0,0,0,3,1));
        vq.push_back(mkv(0,1,0, 1,1,3,0,1,1,3,0,0,1,2,1));
        vq.push_back(mkv(0,1,0, 1,1,0,0,1,1,4,0,0,1,6,1));
        vq.push_back(mkv(0,1,0, 0,0,1,0,1,1,5,1,0,1,7,1));
        // streaming from full: read frees a slot only next cycle, pointers wrap
        vq.push_back(mkv(0,1,1, 0,0,1,1,1,1,5,1,0,1,7,1));
        vq.push_back(mkv(0,1,1, 1,1,1,1,2,1,4,0,0,1,7,3));
        vq.push_back(mkv(0,1,1, 1,1,2,1,3,1,4,0,0,1,5,2));
        vq.push_back(mkv(0,1,1, 1,1,3,1,0,1,4,0,0,1,4,6));
        vq.push_back(mkv(0,1,1, 1,1,0,1,1,1,4,0,0,1,0,7));
        vq.push_back(mkv(0,1,1, 1,1,1,1,2,1,4,0,0,1,1,5));
        vq.push_back(mkv(0,1,1, 1,1,2,1,3,1,4,0,0,1,3,4));
        vq.push_back(mkv(0,1,1, 1,1,3,1,0,1,4,0,0,1,2,0));
        // drain one, then flush at level 3 with a write and a read pending
        vq.push_back(mkv(0,0,1, 1,0,0,1,1,1,4,0,0,1,6,1));
        vq.push_back(mkv(1,1,1, 0,0,0,0,2,1,3,0,0,1,6,3));
        vq.push_back(mkv(0,0,0, 1,0,0,0,0,0,0,0,1,0,0,0));

        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #2;
        chk_reset_outputs("por");
        wr_valid = 1'b1;
        #1;
        chk("por we_gated", 32'(ram_we), 0);
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            flush    = vq[i].flush;
            wr_valid = vq[i].wv;
            rd_ready = vq[i].rr;
            #1;
            chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(vq[i].wrdy));
            chk($sformatf("v%0d ram_we", i),   32'(ram_we),   32'(vq[i].we));
            chk($sformatf("v%0d ram_waddr", i),32'(ram_waddr),32'(vq[i].wa));
            chk($sformatf("v%0d ram_re", i),   32'(ram_re),   32'(vq[i].re));
            chk($sformatf("v%0d ram_raddr", i),32'(ram_raddr),32'(vq[i].ra));
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vq[i].rdv));
            chk($sformatf("v%0d level", i),    32'(level),    32'(vq[i].lvl));
            chk($sformatf("v%0d full", i),     32'(full),     32'(vq[i].full));
            chk($sformatf("v%0d empty", i),    32'(empty),    32'(vq[i].emp));
            chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vq[i].af));
            chk($sformatf("v%0d wr_gray", i),  32'(wr_ptr_gray), 32'(vq[i].wg));
            chk($sformatf("v%0d rd_gray", i),  32'(rd_ptr_gray), 32'(vq[i].rg));
        end

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        flush    = 1'b0;
        wr_valid = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("burst level", 32'(level), 2);
        @(posedge clk);
        #2;
        chk("burst level pre-reset", 32'(level), 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk_reset_outputs("held");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("resume ram_we", 32'(ram_we), 1);
        chk("resume waddr", 32'(ram_waddr), 0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("resume ram_re", 32'(ram_re), 1);
        chk("resume raddr", 32'(ram_raddr), 0);
        chk("resume level", 32'(level), 1);
        @(negedge clk);
        #1;
        chk("resume rd_valid", 32'(rd_valid), 1);
        chk("resume level2", 32'(level), 1);
        chk("resume empty", 32'(empty), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
